world_map_switcher: RTL and testbench
=====================================

WORLD_MAP_SWITCHER -- requirements
Module: world_map_switcher

Interface
REQ-001 Parameter STABLE_CYCLES, default 16: cycles a new map request must hold unchanged before it is accepted.
REQ-002 Parameter HOLD_CYCLES, default 8: cycles bot_hold stays asserted after the map select changes.
REQ-003 Parameter FRAME_TIMEOUT, default 1048576: maximum cycles spent waiting for frame_start before the switch is forced.
REQ-004 clk  input  1  video/robot clock (75 MHz domain); all logic on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 sw_map  input  2  debounced map switches; bit1 = SW14 (LR map), bit0 = SW13 (loop map).
REQ-007 frame_start  input  1  one-cycle pulse at the start of vertical blanking, from the timing generator domain logic.
REQ-008 map_sel  output  2  world-map mux select: 0 = part_1, 1 = loop, 2 = lr; value 3 is never driven.
REQ-009 bot_hold  output  1  active-high hold; ORed into the rojobot reset while the map changes.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 switch_count  output  8  number of completed map switches, saturating.

Function
REQ-012 The requested map shall be decoded combinationally from sw_map with priority: bit1=1 -> 2; else bit0=1 -> 1; else 0.
REQ-013 The FSM shall have states IDLE, WAIT_STABLE, WAIT_FRAME, HOLD and RELEASE.
REQ-014 IDLE: when the requested map differs from map_sel, latch it as target, clear the stable counter and go to WAIT_STABLE next cycle.
REQ-015 WAIT_STABLE: the counter increments each cycle the request equals target; a request change to another non-current map reloads target and clears the counter; a change back to map_sel returns to IDLE.
REQ-016 WAIT_STABLE shall go to WAIT_FRAME on the cycle the counter reaches STABLE_CYCLES-1 with the request still equal to target.
REQ-017 WAIT_FRAME: on frame_start, or when the timeout counter reaches FRAME_TIMEOUT-1, go to HOLD; the timeout counter clears on entry.
REQ-018 WAIT_FRAME: a request change shall take priority over a same-cycle frame_start: go to WAIT_STABLE with the new target, or to IDLE if the request equals map_sel.
REQ-019 A frame_start in the cycle WAIT_FRAME is entered shall not be counted; only pulses seen while in WAIT_FRAME count.
REQ-020 Entering HOLD: bot_hold shall rise and map_sel shall update to target on the same clock edge; both are registered outputs.
REQ-021 HOLD shall last exactly HOLD_CYCLES cycles, ignoring sw_map, then go to RELEASE.
REQ-022 RELEASE shall last one cycle: bot_hold deasserts on entry, switch_count increments saturating at 255, next state IDLE.
REQ-023 A request change made during HOLD or RELEASE shall be serviced as a new sequence from IDLE after RELEASE.
REQ-024 Latency from a stable request change to map_sel update shall be at least 1 + STABLE_CYCLES + 1 cycles plus the frame wait.
REQ-025 All counters shall be sized to hold their parameter value without overflow; the timeout counter is 21 bits for the default.

Reset
REQ-026 While reset_n=0: state=IDLE, map_sel=0, bot_hold=0, busy=0, switch_count=0, all counters cleared.
REQ-027 Reset assertion mid-sequence, including HOLD, shall abort immediately: bot_hold drops asynchronously and map_sel returns to 0.
REQ-028 After reset_n rises with sw_map selecting a non-zero map, a full switch sequence shall run; no shortcut is taken.

Verification
REQ-029 sw_map=00 -> 10 held, frame_start 40 cycles later -> map_sel=2 on the edge after that pulse; bot_hold high 8 cycles; switch_count=1; busy low afterwards.
REQ-030 sw_map toggles 00->01 for 10 cycles then back to 00 -> FSM returns to IDLE; map_sel stays 0; bot_hold never asserts; switch_count=0.
REQ-031 In WAIT_FRAME, sw_map changes 01->11 in the same cycle as frame_start -> no switch; the FSM re-enters WAIT_STABLE with target 2; the next frame_start gives map_sel=2.
REQ-032 frame_start tied low, FRAME_TIMEOUT=100 -> HOLD is entered exactly 100 cycles after WAIT_FRAME entry; map_sel updates.
REQ-033 reset_n pulsed low during the 4th HOLD cycle -> bot_hold=0 and map_sel=0 immediately; after release with sw_map=01, a new sequence reaches map_sel=1.
REQ-034 300 forced switches alternating between maps 0 and 1 -> switch_count saturates at 255 and does not wrap.

Source files
------------

// File: rtl/world_map_switcher.sv
// World map select sequencer: debounces a map request, waits for vertical
// blanking, then swaps the map while holding the rojobot in reset.
`timescale 1ns/1ps
module world_map_switcher #(
    parameter int STABLE_CYCLES = 16,
    parameter int HOLD_CYCLES   = 8,
    parameter int FRAME_TIMEOUT = 1048576
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] sw_map,
    input  logic       frame_start,
    output logic [1:0] map_sel,
    output logic       bot_hold,
    output logic       busy,
    output logic [7:0] switch_count
);

    localparam int STB_W = $clog2(STABLE_CYCLES + 1);
    localparam int HLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int TMO_W = $clog2(FRAME_TIMEOUT + 1);

    localparam logic [STB_W-1:0] STB_LAST = STB_W'(STABLE_CYCLES - 1);
    localparam logic [HLD_W-1:0] HLD_LAST = HLD_W'(HOLD_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(FRAME_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_STABLE,
        WAIT_FRAME,
        HOLD,
        RELEASE
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       req;
    logic [1:0]       target_q, target_d;
    logic [STB_W-1:0] stb_q, stb_d;
    logic [HLD_W-1:0] hld_q, hld_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [1:0]       map_q, map_d;
    logic             hold_q, hold_d;
    logic [7:0]       cnt_q, cnt_d;

    // SW14 (LR map) wins over SW13 (loop map)
    always_comb begin
        if (sw_map[1]) begin
            req = 2'd2;
        end else if (sw_map[0]) begin
            req = 2'd1;
        end else begin
            req = 2'd0;
        end
    end

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        stb_d    = stb_q;
        hld_d    = hld_q;
        tmo_d    = tmo_q;
        map_d    = map_q;
        hold_d   = hold_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (req != map_q) begin
                    target_d = req;
                    stb_d    = '0;
                    state_d  = WAIT_STABLE;
                end
            end
            WAIT_STABLE: begin
                if (req == map_q) begin
                    state_d = IDLE;
                end else if (req != target_q) begin
                    target_d = req;
                    stb_d    = '0;
                end else if (stb_q == STB_LAST) begin
                    tmo_d   = '0;
                    state_d = WAIT_FRAME;
                end else begin
                    stb_d = stb_q + STB_W'(1);
                end
            end
            WAIT_FRAME: begin
                // a changed request outranks a coincident frame pulse
                if (req == map_q) begin
                    state_d = IDLE;
                end else if (req != target_q) begin
                    target_d = req;
                    stb_d    = '0;
                    state_d  = WAIT_STABLE;
                end else if (frame_start || tmo_q == TMO_LAST) begin
                    map_d   = target_q;
                    hold_d  = 1'b1;
                    hld_d   = '0;
                    state_d = HOLD;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            HOLD: begin
                if (hld_q == HLD_LAST) begin
                    hold_d  = 1'b0;
                    state_d = RELEASE;
                    if (cnt_q != 8'hFF) begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end else begin
                    hld_d = hld_q + HLD_W'(1);
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            target_q <= 2'd0;
            stb_q    <= '0;
            hld_q    <= '0;
            tmo_q    <= '0;
            map_q    <= 2'd0;
            hold_q   <= 1'b0;
            cnt_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            stb_q    <= stb_d;
            hld_q    <= hld_d;
            tmo_q    <= tmo_d;
            map_q    <= map_d;
            hold_q   <= hold_d;
            cnt_q    <= cnt_d;
        end
    end

    assign map_sel      = map_q;
    assign bot_hold     = hold_q;
    assign busy         = (state_q != IDLE);
    assign switch_count = cnt_q;

endmodule

// File: tb/tb_world_map_switcher.sv
// Bench for world_map_switcher: directed scenarios plus random requests,
// checked against a request-age model of the switching rules.
`timescale 1ns/1ps
module tb_world_map_switcher;

    localparam int S  = 16;
    localparam int H  = 8;
    localparam int FT = 100;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] sw_map;
    logic       frame_start;
    logic [1:0] map_sel;
    logic       bot_hold;
    logic       busy;
    logic [7:0] switch_count;

    int n_tests = 0;
    int n_fail  = 0;

    // model state: age = consecutive sampled edges the current
    // non-current-map request has been held
    int         m_e     = 0;
    int         m_h     = 0;
    bit         m_has_h = 1'b0;
    int         m_age   = 0;
    logic [1:0] m_last  = 2'd0;
    logic [1:0] m_cur   = 2'd0;
    int         m_cnt   = 0;
    bit         m_hold  = 1'b0;
    bit         m_busy  = 1'b0;

    world_map_switcher #(
        .STABLE_CYCLES(S),
        .HOLD_CYCLES  (H),
        .FRAME_TIMEOUT(FT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .sw_map      (sw_map),
        .frame_start (frame_start),
        .map_sel     (map_sel),
        .bot_hold    (bot_hold),
        .busy        (busy),
        .switch_count(switch_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [1:0] dec(input logic [1:0] s);
        if (s[1]) return 2'd2;
        if (s[0]) return 2'd1;
        return 2'd0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_has_h = 1'b0;
        m_age   = 0;
        m_last  = 2'd0;
        m_cur   = 2'd0;
        m_cnt   = 0;
        m_hold  = 1'b0;
        m_busy  = 1'b0;
    endtask

    task automatic model_edge(input logic [1:0] sw, input logic fs);
        logic [1:0] r;
        m_e++;
        if (m_has_h && m_e == m_h + H && m_cnt < 255) m_cnt++;
        if (m_has_h && m_e <= m_h + H + 1) begin
            m_age = 0;
        end else begin
            r = dec(sw);
            if (r == m_cur) m_age = 0;
            else if (m_age > 0 && r == m_last) m_age++;
            else m_age = 1;
            m_last = r;
            if (m_age > 0 && ((m_age >= S + 2 && fs) || m_age >= S + 1 + FT)) begin
                m_cur   = r;
                m_h     = m_e;
                m_has_h = 1'b1;
                m_age   = 0;
            end
        end
        m_hold = m_has_h && m_e >= m_h && m_e < m_h + H;
        m_busy = (m_age > 0) || (m_has_h && m_e <= m_h + H);
    endtask

    task automatic step(input logic [1:0] sw, input logic fs);
        sw_map      = sw;
        frame_start = fs;
        @(posedge clk);
        model_edge(sw, fs);
        #1;
        chk("map_sel", 32'(map_sel), 32'(m_cur));
        chk("bot_hold", 32'(bot_hold), 32'(m_hold));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("switch_count", 32'(switch_count), 32'(m_cnt));
        frame_start = 1'b0;
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        sw_map      = 2'd0;
        frame_start = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    int n;
    int hold_seen;
    bit hold_any;
    logic [1:0] tgt;
    logic [1:0] rsw;
    logic       rfs;

    initial begin
        reset_n     = 1'b0;
        sw_map      = 2'b00;
        frame_start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_map_sel", 32'(map_sel), 32'd0);
        chk("rst_bot_hold", 32'(bot_hold), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_count", 32'(switch_count), 32'd0);
        reset_n = 1'b1;

        // LR map request, frame pulse 40 cycles later
        repeat (40) step(2'b10, 1'b0);
        step(2'b10, 1'b1);
        chk("lr_map_sel", 32'(map_sel), 32'd2);
        hold_seen = int'(bot_hold);
        for (int i = 0; i < 12; i++) begin
            step(2'b10, 1'b0);
            hold_seen += int'(bot_hold);
        end
        chk("lr_hold_len", 32'(hold_seen), 32'(H));
        chk("lr_count", 32'(switch_count), 32'd1);
        chk("lr_busy_after", 32'(busy), 32'd0);

        // short glitch on loop switch
        do_reset();
        hold_any = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(2'b01, 1'b0);
            hold_any |= bot_hold;
        end
        for (int i = 0; i < 6; i++) begin
            step(2'b00, 1'b0);
            hold_any |= bot_hold;
        end
        chk("glitch_busy", 32'(busy), 32'd0);
        chk("glitch_map", 32'(map_sel), 32'd0);
        chk("glitch_hold", 32'(hold_any), 32'd0);
        chk("glitch_count", 32'(switch_count), 32'd0);

        // request change coincident with frame pulse
        repeat (20) step(2'b01, 1'b0);
        step(2'b11, 1'b1);
        chk("coinc_no_switch", 32'(map_sel), 32'd0);
        chk("coinc_busy", 32'(busy), 32'd1);
        repeat (20) step(2'b11, 1'b0);
        step(2'b11, 1'b1);
        chk("coinc_map2", 32'(map_sel), 32'd2);
        repeat (12) step(2'b11, 1'b0);

        // frame timeout path
        n = 0;
        do begin
            step(2'b01, 1'b0);
            n++;
        end while (map_sel != 2'd1 && n < 200);
        chk("timeout_latency", 32'(n), 32'(1 + S + FT));
        repeat (12) step(2'b01, 1'b0);

        // reset during the fourth HOLD cycle
        repeat (20) step(2'b10, 1'b0);
        step(2'b10, 1'b1);
        repeat (3) step(2'b10, 1'b0);
        chk("pre_abort_hold", 32'(bot_hold), 32'd1);
        #2;
        reset_n = 1'b0;
        sw_map  = 2'b01;
        model_reset();
        #1;
        chk("abort_hold", 32'(bot_hold), 32'd0);
        chk("abort_map", 32'(map_sel), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_count", 32'(switch_count), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        n = 0;
        do begin
            step(2'b01, 1'b0);
            n++;
        end while (map_sel != 2'd1 && n < 200);
        chk("post_abort_map", 32'(map_sel), 32'd1);
        chk("post_abort_latency", 32'(n), 32'(1 + S + FT));
        repeat (12) step(2'b01, 1'b0);

        // 300 forced switches: counter saturation
        for (int i = 0; i < 300; i++) begin
            tgt = (i % 2 == 0) ? 2'b00 : 2'b01;
            repeat (18) step(tgt, 1'b0);
            step(tgt, 1'b1);
            repeat (10) step(tgt, 1'b0);
        end
        chk("sat_count", 32'(switch_count), 32'd255);
        chk("sat_map", 32'(map_sel), 32'd1);

        // random requests and frame pulses
        do_reset();
        rsw = 2'b00;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 29) == 0) rsw = 2'($urandom_range(0, 3));
            rfs = ($urandom_range(0, 39) == 0);
            step(rsw, rfs);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
